riscv_alu_arbiter: RTL and testbench
====================================

# riscv_alu_arbiter

Shares the single EX-stage ALU between two requesters: requester 0 is the integer pipeline (EX issue), requester 1 is an auxiliary client (address-generation / debug unit). The block arbitrates per cycle, registers the granted operands, evaluates them on one instance of the team's `alu` module, and returns each result to its owner through a per-requester response register with valid/ready backpressure. It sits between the ID/EX pipeline register and the EX result path.

## Interface
- No parameters; data is fixed at 32 bits and ALU opcode at 4 bits.
- Clock is `clk` and reset is `rst_n`; `rst_n` is asynchronous and active-low. This is already decided.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `flush` input 1: kills in-flight requester-0 work.
- `req0_valid` input 1: requester 0 presents an operation.
- `req0_ready` output 1: requester 0 is accepted this cycle.
- `req0_input1`, `req0_input2` input 32: ALU operands.
- `req0_alu_op` input 4: ALU opcode. 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR; any other value gives result 0.
- `rsp0_valid` output 1: response 0 is held.
- `rsp0_ready` input 1: requester 0 consumes the response.
- `rsp0_result` output 32: ALU result.
- `rsp0_zero` output 1: asserted when the result equals 0.
- `req1_*` and `rsp1_*`: identical set of ports for requester 1.
- `busy` output 1: the stage-1 register or either response register is valid.

## Operation
- **Stage 1 (operand register).** Holds `s1_valid`, `s1_owner`, operands and opcode. The ALU evaluates the stage-1 contents combinationally.
- **Stage 2 (response registers).** There are two response registers, `rsp0` and `rsp1`. Each holds a result and its zero flag.
- **Stage 1 advance.** Stage 1 advances when `s1_valid`, the owner's response register is empty or drained this cycle (`rspN_valid & rspN_ready`), and the entry is not being flushed.
- **Stage 1 accept.** Stage 1 can accept a new request when it is empty or advancing this cycle.
- **Grant.** If only one `reqN_valid` is high, that requester is granted. If both are high, the requester not granted last is granted (round-robin). The `last` pointer updates only on an accept.
- **Ready.** `reqN_ready` = grant N AND stage 1 can accept AND (N≠0 OR !`flush`).
  - `ready` may depend on `valid`.
  - Requesters must not make `valid` depend on `ready`.
  - Once asserted, a request must hold `valid` and its payload stable until accepted.
- **Accept.** An accept (`reqN_valid & reqN_ready`) loads stage 1 and sets `s1_owner` to N.
- **Response.** On advance, the owner's response register loads the result and zero flag, and its valid bit sets. `rspN_valid` clears on `rspN_ready` unless it is reloaded in the same cycle.
- **Flush.** When `flush` is high:
  - `rsp0_valid` clears.
  - A stage-1 entry owned by requester 0 is discarded.
  - `req0_ready` is forced low.
  - Requester-1 state is unaffected, and requester 1 may be accepted in the same cycle.
- **Reset.** Every output is 0 during reset, except the data outputs `rspN_result`/`rspN_zero`, which reset to 0 / 1. All valid bits are 0, and `last` is 1 so that requester 0 wins the first tie. Reset asserted mid-operation drops all in-flight work with no response.

## Timing
- **Latency.** A request accepted in cycle c has `rspN_valid` high in cycle c+2.
- **Throughput.** One operation per cycle when responses are drained every cycle; back-to-back alternation under contention.
- **Backpressure.** If `rsp0` is full and not drained, a requester-0 entry stalls in stage 1. Both readies are then low, because stage 1 is shared (head-of-line blocking is accepted).
- **Drain and reload in one cycle.** If a response is drained and reloaded in the same cycle, `rspN_valid` stays high and the data updates to the new result.
- **No combinational paths from data.** There is no combinational path from any `reqN_input*` to any `rsp*` output. `reqN_ready` depends only on valids, `flush`, `rspN_ready` and registered state.

## Configuration
- **`ALU_ARB_FIXED_PRIO_EN` defined:** requester 0 wins every tie, and the `last` pointer is not implemented. Requester 1 is served only in cycles where `req0_valid` is low.
- **`ALU_ARB_FIXED_PRIO_EN` undefined:** round-robin arbitration as described under Operation.

## Test plan
- **Single ADD.** `req0` ADD 5+7, `rsp0_ready`=1.
  - `rsp0_valid` is high exactly 2 cycles after accept, with result 12 and zero 0.
  - `busy` returns to 0 the next cycle.
- **Tie under round-robin.** Both requesters valid for 4 cycles, all responses ready.
  - Grants go 0,1,0,1 after reset.
  - Under `ALU_ARB_FIXED_PRIO_EN`, grants go 0,0,0,0 and `req1_ready` stays 0.
- **Backpressure.** `req0` SUB 9−9 with `rsp0_ready`=0, then a second `req0` (XOR 0xF0F0_0000^0x0F0F_0000) and a `req1` OR.
  - `rsp0` holds result 0 with zero 1.
  - Stage 1 stalls, and both readies stay 0 until `rsp0_ready` rises.
  - The held response then drains, and the stalled XOR yields 0xFFFF_0000.
- **Flush.** `flush` asserted while stage 1 holds a `req0` op and `rsp1` holds a result.
  - No `rsp0` is produced.
  - `rsp1` is preserved.
  - A `req1` presented in the flush cycle is accepted.
- **Undefined opcode.** `req1` op 4'b1111 with operands 3 and 4 gives result 0 and zero 1.
- **Reset mid-operation.** `rst_n` dropped asynchronously with stage 1 and `rsp0` valid.
  - All valids go 0 immediately, and `req0_ready` goes 0.
  - After release, no stale response appears.

Source files
------------

// File: rtl/riscv_alu_arbiter.sv
// riscv_alu_arbiter: shares one EX-stage ALU between the integer pipeline (req0) and an auxiliary client (req1).
//   Inputs : clk, rst_n (async, active-low), flush (kills requester-0 work),
//            reqN_valid/reqN_input1/reqN_input2/reqN_alu_op, rspN_ready
//   Outputs: reqN_ready, rspN_valid/rspN_result/rspN_zero, busy
//   Stage 1 registers the granted operands; stage 2 is one response register per requester.
//   Optional: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties, no last pointer).
module alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] y_o,
  output logic        zero_o
);
  always_comb begin
    y_o = op_i == 4'd0 ? a_i + b_i :
          op_i == 4'd1 ? a_i - b_i :
          op_i == 4'd2 ? a_i & b_i :
          op_i == 4'd3 ? a_i | b_i :
          op_i == 4'd4 ? a_i ^ b_i : 32'd0;
    zero_o = y_o == 32'd0;
  end
endmodule

module riscv_alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_input1,
  input  logic [31:0] req0_input2,
  input  logic [3:0]  req0_alu_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_input1,
  input  logic [31:0] req1_input2,
  input  logic [3:0]  req1_alu_op,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic        busy
);
  logic        s1_valid_q, s1_valid_d, s1_owner_q, s1_owner_d;
  logic [31:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [3:0]  s1_op_q, s1_op_d;
  logic        rsp0_valid_q, rsp0_valid_d, rsp0_zero_q, rsp0_zero_d;
  logic        rsp1_valid_q, rsp1_valid_d, rsp1_zero_q, rsp1_zero_d;
  logic [31:0] rsp0_result_q, rsp0_result_d, rsp1_result_q, rsp1_result_d;
  logic [31:0] alu_y;
  logic        alu_zero, owner_free, kill, adv, can_acc, gnt0, gnt1, acc0, acc1, ld0, ld1;

  alu u_alu (.a_i(s1_a_q), .b_i(s1_b_q), .op_i(s1_op_q), .y_o(alu_y), .zero_o(alu_zero));

  assign owner_free = s1_owner_q ? (!rsp1_valid_q || rsp1_ready) : (!rsp0_valid_q || rsp0_ready);
  assign kill       = flush && s1_valid_q && !s1_owner_q;
  assign adv        = s1_valid_q && owner_free && !kill;
  // A flushed requester-0 entry frees stage 1 so requester 1 can be taken in the flush cycle.
  assign can_acc    = !s1_valid_q || adv || kill;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign gnt1 = req1_valid && !req0_valid;
`else
  logic last_q, last_d;
  // last_q == 1 means requester 1 was accepted most recently, so requester 0 wins the next tie.
  assign gnt1   = req1_valid && (!req0_valid || !last_q);
  assign last_d = acc1 ? 1'b1 : acc0 ? 1'b0 : last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else last_q <= last_d;
`endif

  assign gnt0       = req0_valid && !gnt1;
  // rst_n gating keeps ready low while reset is held even though stage 1 is then empty.
  assign req0_ready = rst_n && gnt0 && can_acc && !flush;
  assign req1_ready = rst_n && gnt1 && can_acc;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign ld0        = adv && !s1_owner_q;
  assign ld1        = adv && s1_owner_q;

  always_comb begin
    s1_valid_d    = acc0 || acc1 || (s1_valid_q && !adv && !kill);
    s1_owner_d    = acc1 ? 1'b1 : acc0 ? 1'b0 : s1_owner_q;
    s1_a_d        = acc1 ? req1_input1 : acc0 ? req0_input1 : s1_a_q;
    s1_b_d        = acc1 ? req1_input2 : acc0 ? req0_input2 : s1_b_q;
    s1_op_d       = acc1 ? req1_alu_op : acc0 ? req0_alu_op : s1_op_q;
    rsp0_valid_d  = !flush && (ld0 || (rsp0_valid_q && !rsp0_ready));
    rsp0_result_d = ld0 ? alu_y : rsp0_result_q;
    rsp0_zero_d   = ld0 ? alu_zero : rsp0_zero_q;
    rsp1_valid_d  = ld1 || (rsp1_valid_q && !rsp1_ready);
    rsp1_result_d = ld1 ? alu_y : rsp1_result_q;
    rsp1_zero_d   = ld1 ? alu_zero : rsp1_zero_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_owner_q    <= 1'b0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_op_q       <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b1;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b1;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_owner_q    <= s1_owner_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      s1_op_q       <= s1_op_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_zero_q   <= rsp1_zero_d;
    end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_zero   = rsp1_zero_q;
  assign busy        = s1_valid_q || rsp0_valid_q || rsp1_valid_q;
endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// tb_riscv_alu_arbiter: directed vectors and corner-case sequences for riscv_alu_arbiter.
module tb_riscv_alu_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        req0_valid = 1'b0, req0_ready, rsp0_valid, rsp0_ready = 1'b1, rsp0_zero;
  logic        req1_valid = 1'b0, req1_ready, rsp1_valid, rsp1_ready = 1'b1, rsp1_zero, busy;
  logic [31:0] req0_input1 = '0, req0_input2 = '0, req1_input1 = '0, req1_input2 = '0;
  logic [31:0] rsp0_result, rsp1_result;
  logic [3:0]  req0_alu_op = '0, req1_alu_op = '0;
  int          errors = 0, checks = 0;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  riscv_alu_arbiter dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_input1(req0_input1),
    .req0_input2(req0_input2), .req0_alu_op(req0_alu_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_input1(req1_input1),
    .req1_input2(req1_input2), .req1_alu_op(req1_alu_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        z;
  } vec_t;
  vec_t v[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (r) begin
      req1_valid = 1'b1; req1_alu_op = op; req1_input1 = a; req1_input2 = b;
    end else begin
      req0_valid = 1'b1; req0_alu_op = op; req0_input1 = a; req0_input2 = b;
    end
  endtask

  task automatic do_reset;
    req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step;
  endtask

  initial begin
    v[0] = '{1'b0, 4'd0, 32'd5,          32'd7,          32'd12,         1'b0};
    v[1] = '{1'b0, 4'd1, 32'd9,          32'd9,          32'd0,          1'b1};
    v[2] = '{1'b1, 4'd2, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0F00_0F00,  1'b0};
    v[3] = '{1'b1, 4'd3, 32'hF0F0_0000,  32'h0000_000F,  32'hF0F0_000F,  1'b0};
    v[4] = '{1'b0, 4'd4, 32'hF0F0_0000,  32'h0F0F_0000,  32'hFFFF_0000,  1'b0};
    v[5] = '{1'b1, 4'hF, 32'd3,          32'd4,          32'd0,          1'b1};
    v[6] = '{1'b0, 4'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
    v[7] = '{1'b1, 4'd1, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
    v[8] = '{1'b0, 4'd5, 32'd3,          32'd4,          32'd0,          1'b1};

    // Reset values, with a request pending so ready is meaningful.
    req0_valid = 1'b1;
    #12;
    chk("reset req0_ready", req0_ready, 0);
    chk("reset rsp0_valid", rsp0_valid, 0);
    chk("reset rsp1_valid", rsp1_valid, 0);
    chk("reset rsp0_result", rsp0_result, 0);
    chk("reset rsp0_zero", rsp0_zero, 1);
    chk("reset rsp1_zero", rsp1_zero, 1);
    chk("reset busy", busy, 0);
    do_reset;

    // Single-issue vectors: response exactly two cycles after accept.
    for (int i = 0; i < 9; i++) begin
      int n = 0;
      present(v[i].r, v[i].op, v[i].a, v[i].b);
      #1;
      while (!(v[i].r ? req1_ready : req0_ready) && n < 10) begin
        step; #1; n++;
      end
      chk($sformatf("vec%0d ready", i), v[i].r ? req1_ready : req0_ready, 1);
      step;
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d early valid", i), v[i].r ? rsp1_valid : rsp0_valid, 0);
      step; #1;
      chk($sformatf("vec%0d valid", i), v[i].r ? rsp1_valid : rsp0_valid, 1);
      chk($sformatf("vec%0d result", i), v[i].r ? rsp1_result : rsp0_result, v[i].res);
      chk($sformatf("vec%0d zero", i), v[i].r ? rsp1_zero : rsp0_zero, v[i].z);
      step; #1;
      chk($sformatf("vec%0d busy", i), busy, 0);
    end

    // Tie: round-robin 0,1,0,1 after reset; fixed priority always 0.
    do_reset;
    present(1'b0, 4'd0, 32'd1, 32'd2);
    present(1'b1, 4'd0, 32'd10, 32'd20);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("tie%0d req0_ready", k), req0_ready, (FIXED || k % 2 == 0) ? 1 : 0);
      chk($sformatf("tie%0d req1_ready", k), req1_ready, (!FIXED && k % 2 == 1) ? 1 : 0);
      step;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step; step; step;

    // Backpressure: stalled stage 1 blocks both requesters.
    do_reset;
    rsp0_ready = 1'b0;
    present(1'b0, 4'd1, 32'd9, 32'd9);
    #1; chk("bp sub ready", req0_ready, 1);
    step;
    present(1'b0, 4'd4, 32'hF0F0_0000, 32'h0F0F_0000);
    #1; chk("bp xor ready", req0_ready, 1);
    step;
    req0_valid = 1'b0;
    present(1'b1, 4'd3, 32'd1, 32'd2);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp req1_ready", req1_ready, 0);
      chk("bp rsp0_valid", rsp0_valid, 1);
      chk("bp rsp0_result", rsp0_result, 0);
      chk("bp rsp0_zero", rsp0_zero, 1);
      step; #1;
    end
    rsp0_ready = 1'b1;
    #1; chk("bp release req1_ready", req1_ready, 1);
    step;
    req1_valid = 1'b0;
    #1;
    chk("bp reload valid", rsp0_valid, 1);
    chk("bp xor result", rsp0_result, 32'hFFFF_0000);
    chk("bp xor zero", rsp0_zero, 0);
    step; #1;
    chk("bp rsp0 drained", rsp0_valid, 0);
    chk("bp rsp1_valid", rsp1_valid, 1);
    chk("bp or result", rsp1_result, 3);
    step; step;

    // Flush kills stage-1 req0 op, keeps rsp1, and accepts req1 in the same cycle.
    rsp1_ready = 1'b0;
    present(1'b1, 4'd2, 32'hF, 32'h6);
    #1; chk("fl and ready", req1_ready, 1);
    step;
    req1_valid = 1'b0;
    present(1'b0, 4'd0, 32'd5, 32'd7);
    #1; chk("fl add ready", req0_ready, 1);
    step;
    req0_valid = 1'b0;
    flush = 1'b1;
    present(1'b1, 4'd1, 32'd8, 32'd3);
    #1;
    chk("fl req1_ready", req1_ready, 1);
    chk("fl rsp1 held", rsp1_result, 6);
    step;
    flush = 1'b0; req1_valid = 1'b0; rsp1_ready = 1'b1;
    #1;
    chk("fl no rsp0", rsp0_valid, 0);
    chk("fl rsp1_valid", rsp1_valid, 1);
    chk("fl rsp1 preserved", rsp1_result, 6);
    step; #1;
    chk("fl sub result", rsp1_result, 5);
    chk("fl sub valid", rsp1_valid, 1);
    chk("fl still no rsp0", rsp0_valid, 0);
    step; #1;
    chk("fl idle busy", busy, 0);

    // Asynchronous reset mid-operation.
    do_reset;
    rsp0_ready = 1'b0;
    present(1'b0, 4'd0, 32'd1, 32'd1);
    #1; chk("rst a ready", req0_ready, 1);
    step;
    present(1'b0, 4'd0, 32'd2, 32'd2);
    #1; chk("rst b ready", req0_ready, 1);
    step;
    present(1'b0, 4'd0, 32'd3, 32'd3);
    #1;
    chk("rst pre rsp0_valid", rsp0_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst rsp0_valid", rsp0_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst req0_ready", req0_ready, 0);
    chk("rst rsp0_result", rsp0_result, 0);
    #2;
    rst_n = 1'b1;
    req0_valid = 1'b0; rsp0_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("rst stale rsp0", rsp0_valid, 0);
      chk("rst stale busy", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
